// File: rtl/dt_pkg.sv
// Shared definitions for the decision-tree classifier front end.
// Covers the tree-node word layout, node types, and Q16.16 arithmetic helpers.
package dt_pkg;

    localparam int NUM_FEATURES = 6;
    localparam int FRAC         = 16;
    localparam int DATA_W       = 32;
    localparam int DIFF_W       = 49;
    localparam int PROD_W       = 81;

    localparam int NODE_ID_LSB  = 56;
    localparam int NODE_ID_W    = 8;
    localparam int FEAT_ID_LSB  = 53;
    localparam int FEAT_ID_W    = 3;
    localparam int THRESH_LSB   = 26;
    localparam int THRESH_W     = 27;
    localparam int RIGHT_LSB    = 18;
    localparam int LEFT_LSB     = 10;
    localparam int TYPE_LSB     = 2;
    localparam int CHILD_W      = 8;
    localparam int TYPE_W       = 8;

    localparam logic [7:0] NODE_BENIGN   = 8'h00;
    localparam logic [7:0] NODE_ATTACK   = 8'h01;
    localparam logic [7:0] NODE_INTERNAL = 8'hFF;

    // Clamp a wide signed product to the signed 32-bit Q16.16 range.
    function automatic logic [DATA_W-1:0] sat_q16(input logic signed [PROD_W-1:0] v);
        logic [DATA_W-1:0] r;
        if ((&v[PROD_W-1:DATA_W-1]) || (~|v[PROD_W-1:DATA_W-1])) begin
            r = v[DATA_W-1:0];
        end else if (v[PROD_W-1]) begin
            r = 32'h8000_0000;
        end else begin
            r = 32'h7FFF_FFFF;
        end
        return r;
    endfunction

endpackage

// File: rtl/dt_scale_lane.sv
// One scaling lane: stage 1 subtracts the mean from the Q16.16 raw value.
// Stage 2 multiplies by the reciprocal std, rescales, saturates and holds the result.
module dt_scale_lane
    import dt_pkg::*;
#(
    parameter logic [DATA_W-1:0] MEAN    = 32'h0000_0000,
    parameter logic [DATA_W-1:0] INV_STD = 32'h0001_0000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] raw,
    input  logic              mid_valid,
    output logic [DATA_W-1:0] scaled
);

    logic signed [DIFF_W-1:0] diff_s;
    logic signed [DIFF_W-1:0] diff_r;
    logic signed [PROD_W-1:0] lhs_s;
    logic signed [PROD_W-1:0] rhs_s;
    logic signed [PROD_W-1:0] prod_s;
    logic signed [PROD_W-1:0] shifted_s;
    logic        [DATA_W-1:0] scaled_r;

    // The raw value is unsigned, so a zero MSB keeps it positive in the signed difference.
    assign diff_s = $signed({1'b0, raw, {FRAC{1'b0}}})
                  - $signed({{(DIFF_W-DATA_W){MEAN[DATA_W-1]}}, MEAN});

    assign lhs_s     = {{(PROD_W-DIFF_W){diff_r[DIFF_W-1]}}, diff_r};
    assign rhs_s     = {{(PROD_W-DATA_W){INV_STD[DATA_W-1]}}, INV_STD};
    assign prod_s    = lhs_s * rhs_s;
    assign shifted_s = prod_s >>> FRAC;

    // Stage 1: capture the mean-removed value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            diff_r <= '0;
        end else if (in_valid) begin
            diff_r <= diff_s;
        end
    end

    // Stage 2: capture the saturated scaled value; it holds between completions.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scaled_r <= '0;
        end else if (mid_valid) begin
            scaled_r <= sat_q16(shifted_s);
        end
    end

    assign scaled = scaled_r;

endmodule

// File: rtl/dt_feature_datapath.sv
// Front end of the CAN decision-tree classifier: feature scaling pipeline,
// tree-node field decoder, and registered feature selector.
module dt_feature_datapath
    import dt_pkg::*;
#(
    parameter logic [NUM_FEATURES*DATA_W-1:0] MEANS    = 192'h0,
    parameter logic [NUM_FEATURES*DATA_W-1:0] INV_STDS = {6{32'h0001_0000}}
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        scale_valid_in,
    input  logic [10:0] arb_id_dec,
    input  logic [3:0]  data_length,
    input  logic [7:0]  first_byte,
    input  logic [7:0]  last_byte,
    input  logic [10:0] byte_sum,
    input  logic [31:0] time_delta,
    output logic        scale_valid_out,
    output logic [31:0] feature_0_scaled,
    output logic [31:0] feature_1_scaled,
    output logic [31:0] feature_2_scaled,
    output logic [31:0] feature_3_scaled,
    output logic [31:0] feature_4_scaled,
    output logic [31:0] feature_5_scaled,
    input  logic [63:0] node_data,
    output logic [7:0]  node_id,
    output logic [2:0]  feature_id,
    output logic [26:0] threshold,
    output logic [7:0]  right_child,
    output logic [7:0]  left_child,
    output logic [7:0]  node_type,
    output logic        is_leaf,
    input  logic        sel_valid_in,
    output logic [31:0] selected_feature,
    output logic        sel_valid_out,
    output logic        sel_error
);

    logic [DATA_W-1:0] raw_s  [NUM_FEATURES];
    logic [DATA_W-1:0] feat_s [NUM_FEATURES];
    logic              stage1_valid_r;
    logic              stage2_valid_r;
    logic [DATA_W-1:0] sel_feat_s;
    logic              sel_err_s;
    logic [DATA_W-1:0] selected_r;
    logic              sel_error_r;
    logic              sel_valid_r;
    logic              unused_reserved_s;

    assign node_id     = node_data[NODE_ID_LSB +: NODE_ID_W];
    assign feature_id  = node_data[FEAT_ID_LSB +: FEAT_ID_W];
    assign threshold   = node_data[THRESH_LSB  +: THRESH_W];
    assign right_child = node_data[RIGHT_LSB   +: CHILD_W];
    assign left_child  = node_data[LEFT_LSB    +: CHILD_W];
    assign node_type   = node_data[TYPE_LSB    +: TYPE_W];
    assign is_leaf     = (node_type != NODE_INTERNAL);
    assign unused_reserved_s = ^node_data[1:0];

    assign raw_s[0] = {21'd0, arb_id_dec};
    assign raw_s[1] = {28'd0, data_length};
    assign raw_s[2] = {24'd0, first_byte};
    assign raw_s[3] = {24'd0, last_byte};
    assign raw_s[4] = {21'd0, byte_sum};
    assign raw_s[5] = time_delta;

    for (genvar g = 0; g < NUM_FEATURES; g++) begin : g_lane
        dt_scale_lane #(
            .MEAN    (MEANS[g*DATA_W +: DATA_W]),
            .INV_STD (INV_STDS[g*DATA_W +: DATA_W])
        ) u_lane (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (scale_valid_in),
            .raw       (raw_s[g]),
            .mid_valid (stage1_valid_r),
            .scaled    (feat_s[g])
        );
    end

    // Valid pipeline shadowing the two lane stages.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage1_valid_r <= 1'b0;
            stage2_valid_r <= 1'b0;
        end else begin
            stage1_valid_r <= scale_valid_in;
            stage2_valid_r <= stage1_valid_r;
        end
    end

    // Feature mux; ids 6 and 7 do not address a feature and flag an error.
    always_comb begin
        sel_feat_s = '0;
        sel_err_s  = 1'b0;
        case (feature_id)
            3'd0:    sel_feat_s = feat_s[0];
            3'd1:    sel_feat_s = feat_s[1];
            3'd2:    sel_feat_s = feat_s[2];
            3'd3:    sel_feat_s = feat_s[3];
            3'd4:    sel_feat_s = feat_s[4];
            3'd5:    sel_feat_s = feat_s[5];
            default: begin
                sel_feat_s = '0;
                sel_err_s  = 1'b1;
            end
        endcase
    end

    // Selection register; reads the feature registers before any same-cycle update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            selected_r  <= '0;
            sel_error_r <= 1'b0;
            sel_valid_r <= 1'b0;
        end else begin
            sel_valid_r <= sel_valid_in;
            if (sel_valid_in) begin
                selected_r  <= sel_feat_s;
                sel_error_r <= sel_err_s;
            end
        end
    end

    assign scale_valid_out  = stage2_valid_r;
    assign feature_0_scaled = feat_s[0];
    assign feature_1_scaled = feat_s[1];
    assign feature_2_scaled = feat_s[2];
    assign feature_3_scaled = feat_s[3];
    assign feature_4_scaled = feat_s[4];
    assign feature_5_scaled = feat_s[5];
    assign selected_feature = selected_r;
    assign sel_valid_out    = sel_valid_r;
    assign sel_error        = sel_error_r;

endmodule

// File: tb/tb_dt_feature_datapath.sv
// Scoreboard bench for dt_feature_datapath: scale and select expectations are
// queued at stimulus time and compared when the matching valid pulse appears.
module tb_dt_feature_datapath;
    import dt_pkg::*;

    localparam logic [191:0] MEANS_ALT = {128'h0, 32'h0010_0000, 32'h0};

    logic        clk;
    logic        rst_n;
    logic        scale_valid_in;
    logic [10:0] arb_id_dec;
    logic [3:0]  data_length;
    logic [7:0]  first_byte;
    logic [7:0]  last_byte;
    logic [10:0] byte_sum;
    logic [31:0] time_delta;
    logic [63:0] node_data;
    logic        sel_valid_in;

    logic        scale_valid_out, scale_valid_out_b;
    logic [31:0] f0, f1, f2, f3, f4, f5;
    logic [31:0] g0, g1, g2, g3, g4, g5;
    logic [7:0]  node_id, right_child, left_child, node_type;
    logic [7:0]  node_id_b, right_child_b, left_child_b, node_type_b;
    logic [2:0]  feature_id, feature_id_b;
    logic [26:0] threshold, threshold_b;
    logic        is_leaf, is_leaf_b;
    logic [31:0] selected_feature, selected_feature_b;
    logic        sel_valid_out, sel_valid_out_b;
    logic        sel_error, sel_error_b;

    int n_checks = 0;
    int n_pass   = 0;

    logic [5:0][31:0] sc_q[$];
    logic [32:0]      sel_q[$];
    logic [5:0][31:0] cur_exp;
    logic [5:0][31:0] obs_feat;

    dt_feature_datapath dut (
        .clk(clk), .rst_n(rst_n), .scale_valid_in(scale_valid_in),
        .arb_id_dec(arb_id_dec), .data_length(data_length), .first_byte(first_byte),
        .last_byte(last_byte), .byte_sum(byte_sum), .time_delta(time_delta),
        .scale_valid_out(scale_valid_out),
        .feature_0_scaled(f0), .feature_1_scaled(f1), .feature_2_scaled(f2),
        .feature_3_scaled(f3), .feature_4_scaled(f4), .feature_5_scaled(f5),
        .node_data(node_data), .node_id(node_id), .feature_id(feature_id),
        .threshold(threshold), .right_child(right_child), .left_child(left_child),
        .node_type(node_type), .is_leaf(is_leaf), .sel_valid_in(sel_valid_in),
        .selected_feature(selected_feature), .sel_valid_out(sel_valid_out),
        .sel_error(sel_error)
    );

    // Second instance with a non-zero mean on feature 1 for negative scaling.
    dt_feature_datapath #(.MEANS(MEANS_ALT)) dut_b (
        .clk(clk), .rst_n(rst_n), .scale_valid_in(scale_valid_in),
        .arb_id_dec(arb_id_dec), .data_length(data_length), .first_byte(first_byte),
        .last_byte(last_byte), .byte_sum(byte_sum), .time_delta(time_delta),
        .scale_valid_out(scale_valid_out_b),
        .feature_0_scaled(g0), .feature_1_scaled(g1), .feature_2_scaled(g2),
        .feature_3_scaled(g3), .feature_4_scaled(g4), .feature_5_scaled(g5),
        .node_data(node_data), .node_id(node_id_b), .feature_id(feature_id_b),
        .threshold(threshold_b), .right_child(right_child_b), .left_child(left_child_b),
        .node_type(node_type_b), .is_leaf(is_leaf_b), .sel_valid_in(sel_valid_in),
        .selected_feature(selected_feature_b), .sel_valid_out(sel_valid_out_b),
        .sel_error(sel_error_b)
    );

    assign obs_feat = {f5, f4, f3, f2, f1, f0};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference scaler using wide signed arithmetic, default parameters (mean 0, inv std 1.0).
    function automatic logic [31:0] ref_scale(input logic [31:0] raw, input logic [31:0] mean);
        logic signed [127:0] d;
        logic signed [127:0] p;
        d = $signed({80'd0, raw, 16'd0}) - $signed({{96{mean[31]}}, mean});
        p = d * $signed(128'h1_0000);
        p = p >>> 16;
        if (p > $signed(128'h7FFF_FFFF)) return 32'h7FFF_FFFF;
        else if (p < -$signed(128'h8000_0000)) return 32'h8000_0000;
        else return p[31:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_scale(input logic [10:0] a, input logic [3:0] l, input logic [7:0] fb,
                               input logic [7:0] lb, input logic [10:0] bs, input logic [31:0] td);
        logic [5:0][31:0] e;
        arb_id_dec = a; data_length = l; first_byte = fb;
        last_byte = lb; byte_sum = bs; time_delta = td;
        scale_valid_in = 1'b1;
        e[0] = ref_scale({21'd0, a}, 32'h0);
        e[1] = ref_scale({28'd0, l}, 32'h0);
        e[2] = ref_scale({24'd0, fb}, 32'h0);
        e[3] = ref_scale({24'd0, lb}, 32'h0);
        e[4] = ref_scale({21'd0, bs}, 32'h0);
        e[5] = ref_scale(td, 32'h0);
        sc_q.push_back(e);
        cur_exp = e;
    endtask

    task automatic set_node(input logic [2:0] fid, input logic [7:0] ntype);
        node_data = {8'h05, fid, 27'h000_1234, 8'h0A, 8'h09, ntype, 2'b00};
    endtask

    // Scale scoreboard: every scale_valid_out pulse must match the oldest queued entry.
    always @(negedge clk) begin
        if (rst_n && scale_valid_out) begin
            if (sc_q.size() == 0) begin
                check_eq("unexpected_scale_valid", 64'd1, 64'd0);
            end else begin
                logic [5:0][31:0] e;
                e = sc_q.pop_front();
                for (int k = 0; k < 6; k++) begin
                    check_eq($sformatf("feature_%0d_scaled", k), {32'd0, obs_feat[k]}, {32'd0, e[k]});
                end
            end
        end
    end

    // Select scoreboard.
    always @(negedge clk) begin
        if (rst_n && sel_valid_out) begin
            if (sel_q.size() == 0) begin
                check_eq("unexpected_sel_valid", 64'd1, 64'd0);
            end else begin
                logic [32:0] e;
                e = sel_q.pop_front();
                check_eq("selected_feature", {32'd0, selected_feature}, {32'd0, e[31:0]});
                check_eq("sel_error", {63'd0, sel_error}, {63'd0, e[32]});
            end
        end
    end

    initial begin
        rst_n = 1'b0; scale_valid_in = 1'b0; sel_valid_in = 1'b0;
        arb_id_dec = '0; data_length = '0; first_byte = '0; last_byte = '0;
        byte_sum = '0; time_delta = '0; node_data = '0; cur_exp = '0;
        repeat (2) tick();
        check_eq("rst_scale_valid_out", {63'd0, scale_valid_out}, 64'd0);
        check_eq("rst_features", {32'd0, f0 | f1 | f2 | f3 | f4 | f5}, 64'd0);
        check_eq("rst_sel", {31'd0, selected_feature, sel_valid_out, sel_error}, 64'd0);
        rst_n = 1'b1;
        tick();

        // Nominal scaling vector.
        drive_scale(11'h123, 4'd8, 8'hFF, 8'h00, 11'h3FC, 32'h0000_1000);
        tick(); scale_valid_in = 1'b0;
        repeat (3) tick();
        check_eq("nom_f0", {32'd0, f0}, {32'd0, 32'h0123_0000});
        check_eq("nom_f1", {32'd0, f1}, {32'd0, 32'h0008_0000});
        check_eq("nom_f2", {32'd0, f2}, {32'd0, 32'h00FF_0000});
        check_eq("nom_f3", {32'd0, f3}, 64'd0);
        check_eq("nom_f4", {32'd0, f4}, {32'd0, 32'h03FC_0000});
        check_eq("nom_f5", {32'd0, f5}, {32'd0, 32'h1000_0000});
        check_eq("alt_mean_f1_neg8", {32'd0, g1}, {32'd0, 32'hFFF8_0000});
        check_eq("alt_valid_out_idle", {63'd0, scale_valid_out_b}, 64'd0);

        // Saturation and negative scaling.
        drive_scale(11'h7FF, 4'd4, 8'h80, 8'h7F, 11'h001, 32'h0001_0000);
        tick(); scale_valid_in = 1'b0;
        repeat (3) tick();
        check_eq("sat_f5", {32'd0, f5}, {32'd0, 32'h7FFF_FFFF});
        check_eq("alt_mean_f1_neg12", {32'd0, g1}, {32'd0, 32'hFFF4_0000});
        check_eq("hold_f0", {32'd0, f0}, {32'd0, 32'h07FF_0000});

        // Decoder.
        set_node(3'd2, NODE_INTERNAL);
        #1;
        check_eq("dec_node_id", {56'd0, node_id}, {56'd0, 8'h05});
        check_eq("dec_feature_id", {61'd0, feature_id}, {61'd0, 3'd2});
        check_eq("dec_threshold", {37'd0, threshold}, {37'd0, 27'h000_1234});
        check_eq("dec_right_child", {56'd0, right_child}, {56'd0, 8'h0A});
        check_eq("dec_left_child", {56'd0, left_child}, {56'd0, 8'h09});
        check_eq("dec_node_type", {56'd0, node_type}, {56'd0, 8'hFF});
        check_eq("dec_is_leaf_internal", {63'd0, is_leaf}, 64'd0);
        set_node(3'd2, NODE_ATTACK);
        node_data[1:0] = 2'b11;
        #1;
        check_eq("dec_is_leaf_attack", {63'd0, is_leaf}, 64'd1);
        check_eq("dec_node_type_attack", {56'd0, node_type}, {56'd0, 8'h01});
        set_node(3'd2, NODE_BENIGN);
        #1;
        check_eq("dec_is_leaf_benign", {63'd0, is_leaf}, 64'd1);

        // Random vectors, including back-to-back pulses, then selector sweep.
        for (int r = 0; r < 4; r++) begin
            drive_scale(11'($urandom), 4'($urandom), 8'($urandom), 8'($urandom),
                        11'($urandom), $urandom_range(32'h0000_7FFF, 32'h0));
            tick();
        end
        drive_scale(11'h001, 4'd15, 8'h01, 8'hFE, 11'h7FF, 32'hFFFF_FFFF);
        tick();
        drive_scale(11'h2AA, 4'd3, 8'h55, 8'hAA, 11'h155, 32'h0000_7FFF);
        tick(); scale_valid_in = 1'b0;
        repeat (3) tick();

        for (int fid = 0; fid < 8; fid++) begin
            set_node(3'(fid), NODE_INTERNAL);
            sel_valid_in = 1'b1;
            sel_q.push_back((fid < 6) ? {1'b0, cur_exp[fid]} : {1'b1, 32'h0});
            tick(); sel_valid_in = 1'b0;
            tick();
        end
        tick();
        check_eq("sel_error_hold", {63'd0, sel_error}, 64'd1);
        check_eq("sel_valid_out_idle", {63'd0, sel_valid_out}, 64'd0);

        // Reset one cycle after a scale pulse discards the in-flight result.
        drive_scale(11'h0F0, 4'd2, 8'h10, 8'h20, 11'h030, 32'h0000_0040);
        tick(); scale_valid_in = 1'b0;
        rst_n = 1'b0;
        sc_q.delete();
        sel_q.delete();
        #1;
        check_eq("midrst_valid_out", {63'd0, scale_valid_out}, 64'd0);
        check_eq("midrst_features", {32'd0, f0 | f1 | f2 | f3 | f4 | f5}, 64'd0);
        check_eq("midrst_sel", {31'd0, selected_feature, sel_valid_out, sel_error}, 64'd0);
        tick();
        rst_n = 1'b1;
        repeat (4) tick();
        check_eq("post_rst_features", {32'd0, f0 | f1 | f2 | f3 | f4 | f5}, 64'd0);

        check_eq("scale_queue_drained", 64'(sc_q.size()), 64'd0);
        check_eq("sel_queue_drained", 64'(sel_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/dt_feature_datapath.md
Name: dt_feature_datapath

Overview:
- Front-end datapath of the CAN-bus decision-tree intrusion classifier.
- Scales six raw CAN message features into signed Q16.16 through a 2-stage pipeline.
- Decodes a 64-bit tree-node word into its fields.
- Selects the scaled feature addressed by the decoded node, with a 1-cycle registered handshake, for use by the downstream threshold comparator and the control FSM.

Parameters:
- MEANS, 192'h0: six packed 32-bit signed Q16.16 feature means; feature k occupies bits [32k+31:32k].
- INV_STDS, {6{32'h0001_0000}}: six packed 32-bit signed Q16.16 reciprocal standard deviations, same packing as MEANS.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset
- scale_valid_in  in  1  start-scaling pulse; raw inputs are sampled on this cycle
- arb_id_dec  in  11  raw feature 0
- data_length  in  4  raw feature 1
- first_byte  in  8  raw feature 2
- last_byte  in  8  raw feature 3
- byte_sum  in  11  raw feature 4
- time_delta  in  32  raw feature 5
- scale_valid_out  out  1  scaled-feature-valid pulse
- feature_0_scaled .. feature_5_scaled  out  32 each  signed Q16.16 scaled features
- node_data  in  64  current tree-node word
- node_id  out  8  decoded field
- feature_id  out  3  decoded field
- threshold  out  27  decoded field
- right_child  out  8  decoded field
- left_child  out  8  decoded field
- node_type  out  8  decoded field
- is_leaf  out  1  decoded flag
- sel_valid_in  in  1  select request pulse
- selected_feature  out  32  selected scaled feature
- sel_valid_out  out  1  selection-done pulse
- sel_error  out  1  invalid feature_id flag

Behaviour:
- Reset: rst_n is asynchronous, active-low; clock is clk. While reset is asserted, all registered outputs and all pipeline valids are 0. A reset mid-operation discards any in-flight scale or select, and no valid_out pulse follows it.
- Node decoder (purely combinational, no clock):
  - node_id = node_data[63:56]
  - feature_id = [55:53]
  - threshold = [52:26]
  - right_child = [25:18]
  - left_child = [17:10]
  - node_type = [9:2]
  - bits [1:0] are reserved and ignored
  - is_leaf = (node_type != 8'hFF). 8'h00 is a benign leaf, 8'h01 is an attack leaf, and 8'hFF is an internal node.
- Scaler, stage 1 (registered on the cycle scale_valid_in is high):
  - Each raw input is zero-extended to 32 bits.
  - diff_k = (raw_k << 16) − MEAN_k, computed as a 49-bit signed value.
- Scaler, stage 2 (next cycle):
  - prod_k = diff_k × INV_STD_k, signed multiply.
  - The result is arithmetic-shifted right by 16, truncating toward −∞.
  - It then saturates to [32'h8000_0000, 32'h7FFF_FFFF] and is registered into feature_k_scaled.
- Scaler timing:
  - scale_valid_out is a 1-cycle pulse exactly 2 cycles after scale_valid_in.
  - The pipeline is fully pipelined, so back-to-back scale_valid_in pulses produce back-to-back outputs.
  - The scaled outputs hold their values until overwritten by the next completing scale.
- Selector:
  - On a cycle with sel_valid_in high, it registers selected_feature = feature_<feature_id>_scaled, using the current decoded feature_id.
  - sel_valid_out pulses high on the following cycle, giving a latency of 1.
  - For feature_id 6 or 7: selected_feature = 0 and sel_error = 1. sel_error is registered alongside sel_valid_out and holds until the next sel_valid_in.
  - If sel_valid_in is low, selected_feature and sel_error hold their values.
- Simultaneous events: if a scale completes on the same cycle sel_valid_in is sampled, the selector uses the pre-update (old) feature registers. The controlling FSM never overlaps scale and select.

Decomposition:
- Shared package dt_pkg holds:
  - the node-field bit positions and widths
  - the node_type constants: NODE_BENIGN = 8'h00, NODE_ATTACK = 8'h01, NODE_INTERNAL = 8'hFF
  - NUM_FEATURES = 6
  - the Q16.16 fraction width FRAC = 16
- One natural sub-module, dt_scale_lane: one 2-stage subtract/multiply/saturate lane, instantiated six times.
- The decoder and selector stay inline.

Test Plan:
- Scaling, default parameters:
  - Stimulus: pulse scale_valid_in with arb_id_dec = 0x123, data_length = 8, first_byte = 0xFF, last_byte = 0x00, byte_sum = 0x3FC, time_delta = 0x0000_1000.
  - Required response: 2 cycles later scale_valid_out = 1, and the outputs are 0x0123_0000, 0x0008_0000, 0x00FF_0000, 0, 0x03FC_0000, 0x1000_0000.
- Saturation and negative scaling:
  - Case 1: time_delta = 0x0001_0000 with identity parameters → feature_5_scaled = 0x7FFF_FFFF.
  - Case 2: MEAN_1 = 0x0010_0000 with data_length = 4 → feature_1_scaled = 0xFFF4_0000.
- Decoder:
  - Case 1: node_data = {8'h05, 3'd2, 27'h000_1234, 8'h0A, 8'h09, 8'hFF, 2'b00} → every field decodes to the given value and is_leaf = 0.
  - Case 2: node_type = 8'h01 → is_leaf = 1.
- Selector: after scaling, for each feature_id 0–5, pulse sel_valid_in → 1 cycle later sel_valid_out = 1, selected_feature equals the matching scaled output, and sel_error = 0.
- Selector error: feature_id = 6 or 7 → selected_feature = 0 and sel_error = 1, alongside the sel_valid_out pulse.
- Reset and pipelining:
  - Case 1: assert rst_n low 1 cycle after scale_valid_in → no scale_valid_out pulse, and all outputs are 0.
  - Case 2: two consecutive scale_valid_in pulses → two consecutive scale_valid_out pulses with the correct per-pulse values.
